axi_read_master_m0: RTL and testbench

// - AXI4 read initiator for master port M0. Peer of the read-only SRAM slave S0; reaches it through the bus.
// - Converts a simple core-side burst request (addr, len) into one AR handshake.
// - Collects R beats and returns them through a one-entry registered response slice.
// - One outstanding transaction; checks ID, RRESP and RLAST for every beat.

---
 rtl/axi_pkg.sv | 35 +++
 rtl/axi_r_slice.sv | 45 ++++
 rtl/axi_read_master_m0.sv | 143 ++++++++++++++
 tb/tb_axi_read_master_m0.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 read-path widths, encodings and the response-slice payload type.
package axi_pkg;

  localparam int unsigned AXI_ID_BITS   = 4;
  localparam int unsigned AXI_ADDR_BITS = 32;
  localparam int unsigned AXI_DATA_BITS = 32;
  localparam int unsigned AXI_LEN_BITS  = 4;
  localparam int unsigned AXI_SIZE_BITS = 3;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } rd_state_t;

  typedef struct packed {
    logic [AXI_DATA_BITS-1:0] data;
    logic                     last;
    logic                     err;
  } r_beat_t;

endpackage

// File: rtl/axi_r_slice.sv
// One-entry valid/ready register slice for R beats; accepts a new beat while draining.
module axi_r_slice
  import axi_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    in_valid_i,
  output logic    in_ready_o,
  input  r_beat_t in_beat_i,
  output logic    out_valid_o,
  input  logic    out_ready_i,
  output r_beat_t out_beat_o
);

  logic    valid_q, valid_d;
  r_beat_t beat_q, beat_d;
  logic    load;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign load        = in_valid_i && in_ready_o;
  assign out_valid_o = valid_q;
  assign out_beat_o  = beat_q;

  always_comb begin
    valid_d = valid_q;
    beat_d  = beat_q;
    if (load) begin
      valid_d = 1'b1;
      beat_d  = in_beat_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: rtl/axi_read_master_m0.sv
// AXI4 read initiator for M0: one AR per core request, one outstanding burst,
// per-beat ID/RRESP/RLAST checking, beats returned through a registered slice.
module axi_read_master_m0
  import axi_pkg::*;
#(
  parameter logic [AXI_ID_BITS-1:0]   MASTER_ID  = 4'd0,
  parameter logic [1:0]               BURST_TYPE = 2'b01,
  parameter logic [AXI_SIZE_BITS-1:0] BEAT_SIZE  = 3'b010
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [AXI_ADDR_BITS-1:0] req_addr,
  input  logic [AXI_LEN_BITS-1:0]  req_len,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [AXI_DATA_BITS-1:0] rsp_data,
  output logic                     rsp_last,
  output logic                     rsp_err,
  output logic [AXI_ID_BITS-1:0]   ARID_M0,
  output logic [AXI_ADDR_BITS-1:0] ARADDR_M0,
  output logic [AXI_LEN_BITS-1:0]  ARLEN_M0,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE_M0,
  output logic [1:0]               ARBURST_M0,
  output logic                     ARVALID_M0,
  input  logic                     ARREADY_M0,
  input  logic [AXI_ID_BITS-1:0]   RID_M0,
  input  logic [AXI_DATA_BITS-1:0] RDATA_M0,
  input  logic [1:0]               RRESP_M0,
  input  logic                     RLAST_M0,
  input  logic                     RVALID_M0,
  output logic                     RREADY_M0
);

  rd_state_t                state_q, state_d;
  logic [AXI_ADDR_BITS-1:0] addr_q, addr_d;
  logic [AXI_LEN_BITS-1:0]  len_q, len_d;
  logic [AXI_ID_BITS-1:0]   id_q, id_d;
  logic [AXI_LEN_BITS-1:0]  cnt_q, cnt_d;
  logic                     arvalid_q, arvalid_d;

  logic    slice_in_ready;
  logic    slice_in_valid;
  logic    r_hs;
  logic    beat_last;
  r_beat_t beat_in;
  r_beat_t beat_out;

  assign req_ready  = (state_q == IDLE);
  assign ARID_M0    = id_q;
  assign ARADDR_M0  = addr_q;
  assign ARLEN_M0   = len_q;
  assign ARSIZE_M0  = BEAT_SIZE;
  assign ARBURST_M0 = BURST_TYPE;
  assign ARVALID_M0 = arvalid_q;

  // R is only accepted in DATA, and only when the slice has (or is freeing) room.
  assign slice_in_valid = RVALID_M0 && (state_q == DATA);
  assign RREADY_M0      = (state_q == DATA) && slice_in_ready;
  assign r_hs           = RVALID_M0 && RREADY_M0;
  assign beat_last      = (cnt_q == len_q);

  always_comb begin
    beat_in.data = RDATA_M0;
    beat_in.last = beat_last;
    beat_in.err  = (resp_t'(RRESP_M0) != RESP_OKAY) ||
                   (RID_M0 != MASTER_ID) ||
                   (RLAST_M0 != beat_last);
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    arvalid_d = arvalid_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = req_addr;
          len_d     = req_len;
          id_d      = MASTER_ID;
          arvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (ARREADY_M0) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        // Termination follows the internal count; RLAST only feeds the error flag.
        if (r_hs) begin
          if (beat_last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + AXI_LEN_BITS'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      arvalid_q <= arvalid_d;
    end
  end

  axi_r_slice u_r_slice (
    .clk_i      (ACLK),
    .rst_ni     (ARESETn),
    .in_valid_i (slice_in_valid),
    .in_ready_o (slice_in_ready),
    .in_beat_i  (beat_in),
    .out_valid_o(rsp_valid),
    .out_ready_i(rsp_ready),
    .out_beat_o (beat_out)
  );

  assign rsp_data = beat_out.data;
  assign rsp_last = beat_out.last;
  assign rsp_err  = beat_out.err;

endmodule

// File: tb/tb_axi_read_master_m0.sv
// Directed bench for axi_read_master_m0: scripted AR/R slave, scoreboard of consumed beats.
module tb_axi_read_master_m0;
  import axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic [3:0]  ARID_M0;
  logic [31:0] ARADDR_M0;
  logic [3:0]  ARLEN_M0;
  logic [2:0]  ARSIZE_M0;
  logic [1:0]  ARBURST_M0;
  logic        ARVALID_M0;
  logic        ARREADY_M0 = 1'b0;
  logic [3:0]  RID_M0 = '0;
  logic [31:0] RDATA_M0 = '0;
  logic [1:0]  RRESP_M0 = '0;
  logic        RLAST_M0 = 1'b0;
  logic        RVALID_M0 = 1'b0;
  logic        RREADY_M0;

  always #5 ACLK = ~ACLK;

  axi_read_master_m0 #(
    .MASTER_ID (4'd0),
    .BURST_TYPE(2'b01),
    .BEAT_SIZE (3'b010)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_err(rsp_err),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] bd[16];
  logic [1:0]  bresp[16];
  logic        blast[16];
  logic [3:0]  bid[16];
  logic        el[16];
  logic        ee[16];
  logic [33:0] got_q[$];
  logic [33:0] held;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  // A beat leaves the slice at the next rising edge when both sides are high here.
  always @(negedge ACLK)
    if (ARESETn && rsp_valid && rsp_ready)
      got_q.push_back({rsp_data, rsp_last, rsp_err});

  task automatic set_beats(input logic [3:0] l, input logic [31:0] base);
    for (int unsigned k = 0; k < 16; k++) begin
      bd[k]    = base + 32'(k) * 32'h0001_0101;
      bresp[k] = 2'b00;
      bid[k]   = 4'd0;
      blast[k] = (k == 32'(l));
      el[k]    = (k == 32'(l));
      ee[k]    = 1'b0;
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [3:0] l, input int unsigned ar_delay);
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    #1;
    check("req_ready_idle", req_ready, 1);
    tick;
    req_valid = 1'b0;
    req_addr  = '1;
    req_len   = '1;
    check("arvalid_up", ARVALID_M0, 1);
    check("arid", ARID_M0, 4'd0);
    check("arsize", ARSIZE_M0, 3'b010);
    check("arburst", ARBURST_M0, 2'b01);
    check("req_ready_busy", req_ready, 0);
    for (int unsigned k = 0; k < ar_delay; k++) begin
      check("araddr_hold", ARADDR_M0, a);
      check("arlen_hold", ARLEN_M0, l);
      check("arvalid_hold", ARVALID_M0, 1);
      tick;
    end
    ARREADY_M0 = 1'b1;
    check("araddr_hs", ARADDR_M0, a);
    tick;
    ARREADY_M0 = 1'b0;
    check("arvalid_drop", ARVALID_M0, 0);
  endtask

  task automatic rphase(input logic [3:0] l, input logic [31:0] pat);
    int unsigned i;
    int unsigned cyc;
    logic hs;
    i = 0;
    cyc = 0;
    while (i <= 32'(l) && cyc < 64) begin
      rsp_ready = pat[cyc % 32];
      RVALID_M0 = 1'b1;
      RDATA_M0  = bd[i];
      RRESP_M0  = bresp[i];
      RLAST_M0  = blast[i];
      RID_M0    = bid[i];
      #1;
      hs = RREADY_M0;
      if (rsp_valid && !rsp_ready) check("rready_backpressure", RREADY_M0, 0);
      @(posedge ACLK);
      #1;
      if (hs) i++;
      cyc++;
    end
    RVALID_M0 = 1'b0;
    rsp_ready = 1'b0;
    if (i <= 32'(l)) check("r_timeout_beats", i, 32'(l) + 1);
  endtask

  task automatic drain;
    rsp_ready = 1'b1;
    repeat (3) tick;
    rsp_ready = 1'b0;
    check("drained", rsp_valid, 0);
  endtask

  task automatic compare(input int unsigned n);
    check("beat_count", got_q.size(), n);
    for (int unsigned k = 0; k < n && k < got_q.size(); k++)
      check($sformatf("beat%0d", k), got_q[k], {bd[k], el[k], ee[k]});
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_arvalid", ARVALID_M0, 0);
    check("rst_araddr", ARADDR_M0, 0);
    check("rst_arlen", ARLEN_M0, 0);
    check("rst_arid", ARID_M0, 0);
    check("rst_arsize", ARSIZE_M0, 3'b010);
    check("rst_arburst", ARBURST_M0, 2'b01);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_fields", {rsp_data, rsp_last, rsp_err}, 0);
    check("rst_rready", RREADY_M0, 0);
    tick;

    // Single beat, ARREADY on the third AR cycle, beat held in the slice.
    set_beats(4'd0, 32'h0);
    bd[0] = 32'hDEAD_BEEF;
    issue(32'h0000_0040, 4'd0, 2);
    rphase(4'd0, 32'h0);
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_data", rsp_data, 32'hDEAD_BEEF);
    check("single_rsp_last", rsp_last, 1);
    check("single_rsp_err", rsp_err, 0);
    check("single_idle", req_ready, 1);
    check("single_rready_idle", RREADY_M0, 0);
    drain;
    compare(1);

    // len=3, consumer toggling 1,0,1,0.
    set_beats(4'd3, 32'h1111_0000);
    issue(32'h0000_0100, 4'd3, 0);
    rphase(4'd3, 32'h5555_5555);
    drain;
    compare(4);

    // SLVERR on beat 1 of len=1.
    set_beats(4'd1, 32'h2222_0000);
    bresp[1] = 2'b10;
    ee[1]    = 1'b1;
    issue(32'h0000_0200, 4'd1, 1);
    rphase(4'd1, 32'hFFFF_FFFF);
    drain;
    compare(2);
    check("err_back_idle", req_ready, 1);

    // Early RLAST on beat 0 of len=2.
    set_beats(4'd2, 32'h3333_0000);
    blast[0] = 1'b1;
    ee[0]    = 1'b1;
    issue(32'h0000_0300, 4'd2, 0);
    rphase(4'd2, 32'hFFFF_FFFF);
    drain;
    compare(3);
    check("early_back_idle", req_ready, 1);

    // len=15: 16 beats, wrong RID on beat 5.
    set_beats(4'd15, 32'h4444_0000);
    bid[5] = 4'h3;
    ee[5]  = 1'b1;
    issue(32'h0000_1000, 4'd15, 0);
    rphase(4'd15, 32'hFFFF_FFFF);
    drain;
    compare(16);

    // Back-to-back: new request while the last beat still sits in the slice.
    set_beats(4'd1, 32'h5555_0000);
    issue(32'h0000_2000, 4'd1, 0);
    rphase(4'd1, 32'hFFFF_FFFF);
    check("b2b_held_valid", rsp_valid, 1);
    check("b2b_held_last", rsp_last, 1);
    compare(1);
    held = {32'h5556_0101, 1'b1, 1'b0};
    set_beats(4'd1, 32'h6666_0000);
    issue(32'h0000_3000, 4'd1, 0);
    check("b2b_still_held", rsp_valid, 1);
    rphase(4'd1, 32'hFFFF_FFF8);
    drain;
    check("b2b_count", got_q.size(), 3);
    if (got_q.size() > 0) begin
      check("b2b_first_held", got_q[0], held);
      void'(got_q.pop_front());
    end
    compare(2);

    // Reset mid-DATA with a full slice and RREADY high.
    set_beats(4'd3, 32'h7777_0000);
    issue(32'h0000_4000, 4'd3, 0);
    RVALID_M0 = 1'b1;
    RDATA_M0  = bd[0];
    RLAST_M0  = 1'b0;
    RID_M0    = 4'd0;
    RRESP_M0  = 2'b00;
    #1;
    check("mid_rready_pre", RREADY_M0, 1);
    tick;
    RVALID_M0 = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("mid_rsp_valid_pre", rsp_valid, 1);
    check("mid_rready_drain", RREADY_M0, 1);
    ARESETn = 1'b0;
    #1;
    check("mid_rst_arvalid", ARVALID_M0, 0);
    check("mid_rst_rready", RREADY_M0, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_araddr", ARADDR_M0, 0);
    rsp_ready = 1'b0;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    #1;
    check("mid_rel_req_ready", req_ready, 1);
    check("mid_rel_arlen", ARLEN_M0, 0);
    got_q.delete();
    tick;

    // Fresh single beat after the abandoned burst.
    set_beats(4'd0, 32'h8888_0000);
    issue(32'h0000_5000, 4'd0, 0);
    rphase(4'd0, 32'hFFFF_FFFF);
    drain;
    compare(1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
